// File: rtl/defines_pkg.sv
// Shared geometry, derived sizes and FSM encoding for the MVM stream driver.
package defines_pkg;

  localparam int NROWS_A    = 4;
  localparam int NCOLS_A    = 3;
  localparam int NROWS_B    = 3;
  localparam int NCOLS_B    = 1;
  localparam int NUM_RES    = NROWS_A;
  localparam int FRAME_LEN  = NROWS_A*NCOLS_A + 2*NROWS_B*NCOLS_B;
  localparam int RES_LSIZE  = $clog2(NUM_RES);
  localparam int FLEN_LSIZE = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {DRV_IDLE, DRV_SEND, DRV_RECV, DRV_DONE} drv_state_t;

endpackage

// File: rtl/mvm3_stream_driver_memory.sv
// Generic RAM: synchronous write, registered read with reset; reads beyond SIZE return 0.
module memory #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 16,
  parameter int AW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic             w_wrInRange;
  logic             w_rdInRange;

  // Range checks only exist when SIZE leaves part of the address space unused.
  generate
    if (SIZE == (1 << AW)) begin : g_full
      assign w_wrInRange = 1'b1;
      assign w_rdInRange = 1'b1;
    end else begin : g_part
      assign w_wrInRange = (int'(i_wr_addr) < SIZE);
      assign w_rdInRange = (int'(i_rd_addr) < SIZE);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_wr_en && w_wrInRange) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= w_rdInRange ? r_mem[i_rd_addr] : '0;
    end
  end

endmodule

// File: rtl/mvm3_stream_driver.sv
// Streams a preloaded A/B/X frame into the MVM and collects NUM_RES results.
// Optional overflow counter output ovf_cnt is enabled by defining MVM_DRV_OVF_CNT_EN.
module mvm3_stream_driver #(
  parameter int NROWS_A    = defines_pkg::NROWS_A,
  parameter int NCOLS_A    = defines_pkg::NCOLS_A,
  parameter int NROWS_B    = defines_pkg::NROWS_B,
  parameter int NCOLS_B    = defines_pkg::NCOLS_B,
  parameter int NUM_RES    = NROWS_A,
  parameter int FRAME_LEN  = NROWS_A*NCOLS_A + 2*NROWS_B*NCOLS_B,
  parameter int RES_LSIZE  = $clog2(NUM_RES),
  parameter int FLEN_LSIZE = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_wr_en,
  input  logic [FLEN_LSIZE-1:0] cfg_addr,
  input  logic signed [7:0]     cfg_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  tx_valid,
  output logic signed [7:0]     tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic signed [15:0]    rx_data,
  input  logic                  rx_overflow,
  output logic                  rx_ready,
  input  logic [RES_LSIZE-1:0]  res_addr,
  output logic [16:0]           res_data,
  output logic                  any_ovf
`ifdef MVM_DRV_OVF_CNT_EN
  ,
  output logic [RES_LSIZE:0]    ovf_cnt
`endif
);

  import defines_pkg::*;

  localparam int FW = FLEN_LSIZE + 1;

  drv_state_t           r_state;
  logic [FW-1:0]        r_fetchAddr;
  logic [FW-1:0]        r_beatCnt;
  logic [RES_LSIZE-1:0] r_resCnt;
  logic                 r_memValid;
  logic                 r_txValid;
  logic [7:0]           r_txData;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rxReady;
  logic                 r_anyOvf;

  logic [7:0]           w_memData;
  logic [FW-1:0]        w_rdAddr;
  logic                 w_txXfer;
  logic                 w_take;
  logic                 w_lastBeat;
  logic                 w_rxAcc;
  logic                 w_lastRes;
  logic                 w_cfgWe;

  // The RAM output acts as the prefetch stage; its address only advances when the beat it holds moves into tx_data.
  assign w_txXfer   = r_txValid & tx_ready;
  assign w_take     = r_memValid & (~r_txValid | tx_ready);
  assign w_rdAddr   = w_take ? r_fetchAddr + 1'b1 : r_fetchAddr;
  assign w_lastBeat = w_txXfer && (r_beatCnt == FW'(FRAME_LEN - 1));
  assign w_rxAcc    = rx_valid & r_rxReady;
  assign w_lastRes  = w_rxAcc && (r_resCnt == RES_LSIZE'(NUM_RES - 1));
  assign w_cfgWe    = cfg_wr_en & ~r_busy;

  memory #(
    .WIDTH (8),
    .SIZE  (FRAME_LEN)
  ) u_frameBuf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_cfgWe),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_data),
    .i_rd_addr (w_rdAddr[FLEN_LSIZE-1:0]),
    .o_rd_data (w_memData)
  );

  memory #(
    .WIDTH (17),
    .SIZE  (NUM_RES)
  ) u_resBuf (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_rxAcc),
    .i_wr_addr (r_resCnt),
    .i_wr_data ({rx_overflow, rx_data}),
    .i_rd_addr (res_addr),
    .o_rd_data (res_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= DRV_IDLE;
      r_fetchAddr <= '0;
      r_beatCnt   <= '0;
      r_resCnt    <= '0;
      r_memValid  <= 1'b0;
      r_txValid   <= 1'b0;
      r_txData    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rxReady   <= 1'b0;
      r_anyOvf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DRV_IDLE: begin
          if (start) begin
            r_state     <= DRV_SEND;
            r_busy      <= 1'b1;
            r_fetchAddr <= '0;
            r_memValid  <= 1'b0;
            r_beatCnt   <= '0;
            r_resCnt    <= '0;
            r_anyOvf    <= 1'b0;
          end
        end
        DRV_SEND: begin
          r_fetchAddr <= w_rdAddr;
          r_memValid  <= (w_rdAddr < FW'(FRAME_LEN));
          if (w_take) begin
            r_txValid <= 1'b1;
            r_txData  <= w_memData;
          end else if (w_txXfer) begin
            r_txValid <= 1'b0;
          end
          if (w_txXfer) begin
            r_beatCnt <= r_beatCnt + 1'b1;
          end
          if (w_lastBeat) begin
            r_state    <= DRV_RECV;
            r_beatCnt  <= '0;
            r_memValid <= 1'b0;
            r_rxReady  <= 1'b1;
          end
        end
        DRV_RECV: begin
          if (w_rxAcc) begin
            if (rx_overflow) begin
              r_anyOvf <= 1'b1;
            end
            if (w_lastRes) begin
              r_state   <= DRV_DONE;
              r_resCnt  <= '0;
              r_rxReady <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_resCnt <= r_resCnt + 1'b1;
            end
          end
        end
        DRV_DONE: begin
          r_state <= DRV_IDLE;
        end
        default: begin
          r_state <= DRV_IDLE;
        end
      endcase
    end
  end

`ifdef MVM_DRV_OVF_CNT_EN
  logic [RES_LSIZE:0] r_ovfCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovfCnt <= '0;
    end else if (r_state == DRV_IDLE && start) begin
      r_ovfCnt <= '0;
    end else if (w_rxAcc && rx_overflow && r_ovfCnt != (RES_LSIZE+1)'(NUM_RES)) begin
      r_ovfCnt <= r_ovfCnt + 1'b1;
    end
  end

  assign ovf_cnt = r_ovfCnt;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign tx_valid = r_txValid;
  assign tx_data  = r_txData;
  assign rx_ready = r_rxReady;
  assign any_ovf  = r_anyOvf;

endmodule

// File: tb/tb_mvm3_stream_driver.sv
// Bench for mvm3_stream_driver: TX beats are scoreboarded against a frame model, the bench plays the MVM.
module tb_mvm3_stream_driver;

  import defines_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cfg_wr_en;
  logic [FLEN_LSIZE-1:0] cfg_addr;
  logic signed [7:0]     cfg_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  tx_valid;
  logic signed [7:0]     tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic signed [15:0]    rx_data;
  logic                  rx_overflow;
  logic                  rx_ready;
  logic [RES_LSIZE-1:0]  res_addr;
  logic [16:0]           res_data;
  logic                  any_ovf;
`ifdef MVM_DRV_OVF_CNT_EN
  logic [RES_LSIZE:0]    ovf_cnt;
`endif

  int  vectors     = 0;
  int  miscompares = 0;
  byte frameModel[FRAME_LEN];
  byte txExpQ[$];
  int  beatsSeen   = 0;
  int  doneCount   = 0;
  bit  prevStall   = 0;
  bit  lastBeatPending = 0;

  mvm3_stream_driver dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_overflow (rx_overflow),
    .rx_ready    (rx_ready),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .any_ovf     (any_ovf)
`ifdef MVM_DRV_OVF_CNT_EN
    ,
    .ovf_cnt     (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected beat on every TX transfer and watches the handshake rules.
  always @(negedge clk) begin
    byte e;
    if (!reset) begin
      if (done) doneCount++;
      if (lastBeatPending) begin
        checkOutput("txValidDropAfterLast", 32'(tx_valid), 0);
        lastBeatPending = 0;
      end
      if (prevStall) checkOutput("txValidHeldInStall", 32'(tx_valid), 1);
      if (tx_valid && tx_ready) begin
        if (txExpQ.size() == 0) begin
          checkOutput("txExtraBeat", 32'(tx_valid), 0);
        end else begin
          e = txExpQ.pop_front();
          checkOutput("txBeat", 32'(tx_data), 32'(e));
        end
        beatsSeen++;
        if (beatsSeen == FRAME_LEN) lastBeatPending = 1;
      end
      prevStall = tx_valid && !tx_ready;
    end else begin
      prevStall       = 0;
      lastBeatPending = 0;
    end
  end

  function automatic logic nextReady(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1 && cyc <= 4) return (cyc == 1 || cyc == 4);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic loadFrame(input bit sequential);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(posedge clk); #1;
      cfg_wr_en = 1'b1;
      cfg_addr  = FLEN_LSIZE'(i);
      cfg_data  = sequential ? 8'(i + 1) : 8'($urandom);
      frameModel[i] = cfg_data;
    end
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // One frame: resMode 0 random results, 1 the fixed signed table, 2 random data with overflow on results 0 and 2.
  task automatic applyStimulus(input int mode, input bit midStart, input bit cfgInRecv,
                               input bit resetMid, input bit wrWithStart, input int resMode);
    logic signed [15:0] resData[NUM_RES];
    bit resOvf[NUM_RES];
    logic signed [15:0] fixedData[4];
    bit fixedOvf[4];
    int expOvf;
    int k;
    int cyc;
    bit accepted;
    bit wrPending;
    bit wrDone;

    fixedData = '{-16'sd5, 16'sd300, 16'sd32767, 16'sd0};
    fixedOvf  = '{1'b0, 1'b0, 1'b1, 1'b0};
    expOvf = 0;
    for (int i = 0; i < NUM_RES; i++) begin
      if (resMode == 1) begin
        resData[i] = fixedData[i % 4];
        resOvf[i]  = fixedOvf[i % 4];
      end else begin
        resData[i] = 16'($urandom);
        resOvf[i]  = (resMode == 2) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      end
      if (resOvf[i]) expOvf++;
    end

    @(posedge clk); #1;
    if (wrWithStart) begin
      cfg_wr_en = 1'b1;
      cfg_addr  = '0;
      cfg_data  = 8'($urandom);
      frameModel[0] = cfg_data;
    end
    txExpQ.delete();
    for (int i = 0; i < FRAME_LEN; i++) txExpQ.push_back(frameModel[i]);
    beatsSeen   = 0;
    doneCount   = 0;
    rx_valid    = 1'b1;
    rx_data     = resData[0];
    rx_overflow = resOvf[0];
    tx_ready    = 1'b1;
    start       = 1'b1;

    @(posedge clk); #1;
    start     = 1'b0;
    cfg_wr_en = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 1);
    checkOutput("anyOvfClearedOnStart", 32'(any_ovf), 0);
`ifdef MVM_DRV_OVF_CNT_EN
    checkOutput("ovfCntClearedOnStart", 32'(ovf_cnt), 0);
`endif
    checkOutput("txValidStartPlus1", 32'(tx_valid), 0);
    checkOutput("rxReadyLowInSend", 32'(rx_ready), 0);
    @(posedge clk); #1;
    checkOutput("txValidStartPlus2Pre", 32'(tx_valid), 0);
    @(posedge clk); #1;
    checkOutput("txValidStartPlus2", 32'(tx_valid), 1);

    cyc = 0;
    while (beatsSeen < FRAME_LEN && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      tx_ready = nextReady(mode, cyc);
      start    = (midStart && cyc == 3);
      if (resetMid && cyc == 4) begin
        reset = 1'b1;
        #1;
        checkOutput("resetTxValid", 32'(tx_valid), 0);
        checkOutput("resetBusy", 32'(busy), 0);
        checkOutput("resetTxData", 32'(tx_data), 0);
        checkOutput("resetRxReady", 32'(rx_ready), 0);
        @(posedge clk); #1;
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        txExpQ.delete();
        return;
      end
    end
    start = 1'b0;
    checkOutput("sendBeatCount", beatsSeen, FRAME_LEN);

    k = 0;
    cyc = 0;
    wrPending = 0;
    wrDone = 0;
    while (k < NUM_RES && cyc < 100) begin
      @(negedge clk);
      accepted = rx_valid && rx_ready;
      if (cfgInRecv && rx_ready && !wrDone) begin
        wrPending = 1;
        wrDone    = 1;
      end
      @(posedge clk); #1;
      cyc++;
      cfg_wr_en = wrPending;
      cfg_addr  = '0;
      cfg_data  = ~frameModel[0];
      wrPending = 0;
      if (accepted) k++;
      if (k < NUM_RES && (accepted || !rx_valid)) begin
        if (accepted && $urandom_range(0, 3) == 0) begin
          rx_valid = 1'b0;
        end else begin
          rx_valid    = 1'b1;
          rx_data     = resData[k];
          rx_overflow = resOvf[k];
        end
      end else if (k == NUM_RES) begin
        rx_valid = 1'b0;
      end
    end
    cfg_wr_en = 1'b0;
    rx_valid  = 1'b0;
    checkOutput("recvResultCount", k, NUM_RES);

    @(negedge clk);
    checkOutput("doneHigh", 32'(done), 1);
    checkOutput("busyLowInDone", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("donePulses", doneCount, 1);
    checkOutput("anyOvf", 32'(any_ovf), (expOvf != 0) ? 1 : 0);
`ifdef MVM_DRV_OVF_CNT_EN
    checkOutput("ovfCnt", 32'(ovf_cnt), expOvf);
`endif
    for (int a = 0; a < NUM_RES; a++) begin
      res_addr = RES_LSIZE'(a);
      @(posedge clk); #1;
      checkOutput($sformatf("resData%0d", a), 32'(res_data), 32'({resOvf[a], resData[a]}));
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_addr    = '0;
    cfg_data    = '0;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = '0;
    rx_overflow = 1'b0;
    res_addr    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstDone", 32'(done), 0);
    checkOutput("rstTxValid", 32'(tx_valid), 0);
    checkOutput("rstRxReady", 32'(rx_ready), 0);
    checkOutput("rstAnyOvf", 32'(any_ovf), 0);
    checkOutput("rstTxData", 32'(tx_data), 0);
    checkOutput("rstResData", 32'(res_data), 0);
    reset = 1'b0;

    loadFrame(1);
    $display("[TB] frame 1: sequential beats, tx_ready held high, fixed results");
    applyStimulus(0, 0, 0, 0, 0, 1);
    $display("[TB] frame 2: two of four results overflow");
    applyStimulus(0, 0, 0, 0, 0, 2);
    $display("[TB] frame 3: 1,0,0,1 stalls, start during SEND, cfg write during RECV");
    applyStimulus(1, 1, 1, 0, 0, 0);
    $display("[TB] frame 4: same buffer, random tx_ready");
    applyStimulus(2, 0, 0, 0, 0, 0);
    loadFrame(0);
    $display("[TB] frame 5: reset mid-SEND");
    applyStimulus(2, 0, 0, 1, 0, 0);
    $display("[TB] frame 6: replay with cfg write in the start cycle");
    applyStimulus(2, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
